// File: rtl/lpc_pkg.sv
// Shared G.729 LPC basic operators (saturating 16/32-bit arithmetic) and lag-window constants.
package lpc_pkg;

    localparam int ORDER = 10;

    localparam logic signed [31:0] MAX_32 = 32'sh7FFF_FFFF;
    localparam logic signed [31:0] MIN_32 = 32'sh8000_0000;

    localparam logic signed [15:0] LAG_H [0:9] = '{
        16'sd32728, 16'sd32619, 16'sd32438, 16'sd32187, 16'sd31867,
        16'sd31480, 16'sd31029, 16'sd30517, 16'sd29946, 16'sd29321
    };
    localparam logic signed [15:0] LAG_L [0:9] = '{
        16'sd11904, 16'sd17280, 16'sd30720, 16'sd25856, 16'sd24192,
        16'sd28992, 16'sd24384, 16'sd7360,  16'sd19520, 16'sd14784
    };

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_WAIT, S_CALC, S_WRITE, S_DONE
    } lag_state_e;

    function automatic logic signed [31:0] sat32(input logic signed [33:0] v);
        if (v > 34'sd2147483647)  return MAX_32;
        if (v < -34'sd2147483648) return MIN_32;
        return v[31:0];
    endfunction

    function automatic logic signed [31:0] L_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b);
        return sat32(34'(a) + 34'(b));
    endfunction

    function automatic logic signed [31:0] L_mult(input logic signed [15:0] a,
                                                  input logic signed [15:0] b);
        logic signed [33:0] p;
        p = 34'(a) * 34'(b);
        return sat32(p <<< 1);
    endfunction

    // Only -32768 * -32768 can exceed the 16-bit range after the shift.
    function automatic logic signed [15:0] mult(input logic signed [15:0] a,
                                                input logic signed [15:0] b);
        logic signed [31:0] p;
        p = (32'(a) * 32'(b)) >>> 15;
        if (p > 32'sd32767) return 16'sh7FFF;
        return p[15:0];
    endfunction

    function automatic logic signed [31:0] L_mac(input logic signed [31:0] acc,
                                                 input logic signed [15:0] a);
        return L_add(acc, 32'(a) <<< 1);
    endfunction

endpackage

// File: rtl/mpy_32.sv
// Double-precision 32x32 multiply in G.729 hi/lo form; purely combinational.
module mpy_32
    import lpc_pkg::*;
(
    input  logic signed [15:0] hi1,
    input  logic signed [15:0] lo1,
    input  logic signed [15:0] hi2,
    input  logic signed [15:0] lo2,
    output logic signed [31:0] result
);

    logic signed [31:0] w_acc0;
    logic signed [31:0] w_acc1;

    always_comb begin
        w_acc0 = L_mult(hi1, hi2);
        w_acc1 = L_mac(w_acc0, mult(hi1, lo2));
        result = L_mac(w_acc1, mult(lo1, hi2));
    end

endmodule

// File: rtl/lag_window.sv
// Lag-windows r[1..ORDER] in place in scratch memory: read, wait, multiply, write back per lag.
module lag_window #(
    parameter logic [11:0] R_BASE = 12'd0,
    parameter int          ORDER  = lpc_pkg::ORDER
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] memIn,
    output logic [11:0] readRequested,
    output logic [11:0] writeRequested,
    output logic [31:0] memOut,
    output logic        writeEn,
    output logic        done
);
    import lpc_pkg::*;

    lag_state_e         r_state;
    logic [3:0]         r_i;
    logic               r_start_q;
    logic               r_start_qq;
    logic [31:0]        r_data;

    logic               w_rise;
    logic signed [15:0] w_hi1;
    logic signed [15:0] w_lo1;
    logic signed [15:0] w_lag_h;
    logic signed [15:0] w_lag_l;
    logic signed [31:0] w_prod;
    logic [11:0]        w_addr;

    assign w_rise = r_start_q & ~r_start_qq;
    assign w_addr = R_BASE + 12'(r_i);

    // L_Extract: lo = (L>>>1) - (hi<<15) is just bits [15:1].
    assign w_hi1 = r_data[31:16];
    assign w_lo1 = {1'b0, r_data[15:1]};

    always_comb begin
        w_lag_h = LAG_H[0];
        w_lag_l = LAG_L[0];
        case (r_i)
            4'd2:    begin w_lag_h = LAG_H[1]; w_lag_l = LAG_L[1]; end
            4'd3:    begin w_lag_h = LAG_H[2]; w_lag_l = LAG_L[2]; end
            4'd4:    begin w_lag_h = LAG_H[3]; w_lag_l = LAG_L[3]; end
            4'd5:    begin w_lag_h = LAG_H[4]; w_lag_l = LAG_L[4]; end
            4'd6:    begin w_lag_h = LAG_H[5]; w_lag_l = LAG_L[5]; end
            4'd7:    begin w_lag_h = LAG_H[6]; w_lag_l = LAG_L[6]; end
            4'd8:    begin w_lag_h = LAG_H[7]; w_lag_l = LAG_L[7]; end
            4'd9:    begin w_lag_h = LAG_H[8]; w_lag_l = LAG_L[8]; end
            4'd10:   begin w_lag_h = LAG_H[9]; w_lag_l = LAG_L[9]; end
            default: begin w_lag_h = LAG_H[0]; w_lag_l = LAG_L[0]; end
        endcase
    end

    mpy_32 u_mpy (
        .hi1    (w_hi1),
        .lo1    (w_lo1),
        .hi2    (w_lag_h),
        .lo2    (w_lag_l),
        .result (w_prod)
    );

    // Read address is parked on R_BASE after READ so it never collides with the write address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_i            <= 4'd1;
            r_start_q      <= 1'b0;
            r_start_qq     <= 1'b0;
            r_data         <= '0;
            readRequested  <= R_BASE;
            writeRequested <= R_BASE;
            memOut         <= '0;
            writeEn        <= 1'b0;
            done           <= 1'b0;
        end else begin
            r_start_q  <= start;
            r_start_qq <= r_start_q;
            writeEn    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        r_state       <= S_READ;
                        readRequested <= w_addr;
                    end
                end
                S_READ: begin
                    r_state       <= S_WAIT;
                    readRequested <= R_BASE;
                end
                S_WAIT: begin
                    r_state <= S_CALC;
                    r_data  <= memIn;
                end
                S_CALC: begin
                    r_state        <= S_WRITE;
                    writeEn        <= 1'b1;
                    writeRequested <= w_addr;
                    memOut         <= w_prod;
                end
                S_WRITE: begin
                    if (r_i == 4'(ORDER)) begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                    end else begin
                        r_state       <= S_READ;
                        r_i           <= r_i + 4'd1;
                        readRequested <= w_addr + 12'd1;
                    end
                end
                S_DONE: begin
                    if (!start) begin
                        r_state        <= S_IDLE;
                        r_i            <= 4'd1;
                        done           <= 1'b0;
                        writeRequested <= R_BASE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
